// File: rtl/bus_fabric_pkg.sv
// rtl/bus_fabric_pkg.sv - shared FSM type, default strobe addresses and region field helpers
package bus_fabric_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} fsm_state_e;

  localparam logic [15:0] IRQACK_DEF  = 16'h6080;
  localparam logic [15:0] WDCLR_DEF   = 16'h5800;
  localparam int          FIELD_VEC_W = 1024;

  // Extracts field idx of width w (<= 32) from a packed parameter vector.
  function automatic logic [31:0] field_of(input logic [FIELD_VEC_W-1:0] vec,
                                           input int idx, input int w);
    logic [FIELD_VEC_W-1:0] s;
    field_of = '0;
    s = vec >> (idx * w);
    for (int b = 0; b < 32; b++) begin
      if (b < w) field_of[b] = s[b];
    end
  endfunction

endpackage

// File: rtl/bus_irq_watchdog.sv
// rtl/bus_irq_watchdog.sv - periodic IRQ divider with acknowledge, plus IRQ-period watchdog
module bus_irq_watchdog #(
  parameter int IRQ_DIV  = 12,
  parameter int WD_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_3k,
  input  logic irq_ack,
  input  logic wd_clr,
  output logic irq_n,
  output logic wd_reset
);

  localparam int IW = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;
  localparam int WW = $clog2(WD_LIMIT + 1);

  logic [IW-1:0] icnt_q, icnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          irq_n_q, irq_n_d;
  logic          wd_reset_q, wd_reset_d;
  logic          fire;

  always_comb begin
    icnt_d     = icnt_q;
    fire       = 1'b0;
    irq_n_d    = irq_n_q;
    wd_d       = wd_q;
    wd_reset_d = 1'b0;

    if (tick_3k) begin
      if (icnt_q == IW'(IRQ_DIV - 1)) begin
        icnt_d = '0;
        fire   = 1'b1;
      end else begin
        icnt_d = icnt_q + 1'b1;
      end
    end

    // A new assertion beats an acknowledge landing in the same cycle.
    if (fire)         irq_n_d = 1'b0;
    else if (irq_ack) irq_n_d = 1'b1;

    if (wd_clr) begin
      wd_d = '0;
    end else if (fire) begin
      if (wd_q == WW'(WD_LIMIT - 1)) begin
        wd_d       = '0;
        wd_reset_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q     <= '0;
      wd_q       <= '0;
      irq_n_q    <= 1'b1;
      wd_reset_q <= 1'b0;
    end else begin
      icnt_q     <= icnt_d;
      wd_q       <= wd_d;
      irq_n_q    <= irq_n_d;
      wd_reset_q <= wd_reset_d;
    end
  end

  assign irq_n    = irq_n_q;
  assign wd_reset = wd_reset_q;

endmodule

// File: rtl/cpu_bus_fabric.sv
// rtl/cpu_bus_fabric.sv - CPU bus region decode, read mux, wait-state FSM, IRQ timer and watchdog
module cpu_bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                   NREG     = 4,
  parameter int                   AW       = 16,
  parameter int                   DW       = 8,
  parameter logic [NREG*AW-1:0]   REG_BASE = '0,
  parameter logic [NREG*AW-1:0]   REG_MASK = {NREG{AW'(16'hF000)}},
  parameter logic [NREG*4-1:0]    REG_WAIT = '0,
  parameter int                   IRQ_DIV  = 12,
  parameter int                   WD_LIMIT = 16,
  parameter logic [AW-1:0]        IRQACK_A = AW'(IRQACK_DEF),
  parameter logic [AW-1:0]        WDCLR_A  = AW'(WDCLR_DEF)
) (
  input  logic                 clk_96MHz,
  input  logic                 RESET,
  input  logic                 cpu_en,
  input  logic                 tick_3k,
  input  logic [AW-1:0]        addr,
  input  logic                 R_Wn,
  input  logic [DW-1:0]        din,
  output logic [DW-1:0]        dout,
  output logic                 cpu_rdy,
  input  logic                 halt,
  output logic [NREG-1:0]      sel,
  output logic                 wr_en,
  input  logic [NREG*DW-1:0]   rd_data,
  output logic                 irq_n,
  output logic                 wd_reset
);

  logic [NREG-1:0] raw_hit, hit;
  logic [DW-1:0]   rd_slice   [NREG];
  logic [3:0]      wait_slice [NREG];
  logic [DW-1:0]   rdata_sel;
  logic [3:0]      wait_sel;

  // Write data passes straight to the regions; the fabric itself never looks at it.
  logic unused_din;
  assign unused_din = ^din;

  for (genvar i = 0; i < NREG; i++) begin : g_dec
    localparam logic [AW-1:0] BASE_I = AW'(field_of(FIELD_VEC_W'(REG_BASE), i, AW));
    localparam logic [AW-1:0] MASK_I = AW'(field_of(FIELD_VEC_W'(REG_MASK), i, AW));
    localparam logic [3:0]    WAIT_I = 4'(field_of(FIELD_VEC_W'(REG_WAIT), i, 4));

    assign raw_hit[i] = ((addr & MASK_I) == BASE_I);
    if (i == 0) begin : g_first
      assign hit[i] = raw_hit[i];
    end else begin : g_rest
      assign hit[i] = raw_hit[i] & ~(|raw_hit[i-1:0]);
    end
    assign rd_slice[i]   = hit[i] ? rd_data[i*DW +: DW] : '0;
    assign wait_slice[i] = hit[i] ? WAIT_I : 4'd0;
  end

  always_comb begin
    rdata_sel = '0;
    wait_sel  = '0;
    for (int i = 0; i < NREG; i++) begin
      rdata_sel = rdata_sel | rd_slice[i];
      wait_sel  = wait_sel | wait_slice[i];
    end
  end

  fsm_state_e    state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          live_q, live_d;
  logic          adv, stall, complete, wr_done;

  // live_q masks the combinational outputs so RESET forces them idle asynchronously.
  assign adv = cpu_en & ~halt & live_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dout_d   = dout_q;
    live_d   = 1'b1;
    stall    = 1'b0;
    complete = 1'b0;

    case (state_q)
      ST_WAIT: begin
        stall = (wcnt_q != 4'd1);
        if (adv) begin
          if (wcnt_q == 4'd1) begin
            state_d  = ST_DONE;
            complete = 1'b1;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end
      default: begin
        // DONE is a one-cycle ready gap; a strobe arriving in it starts a fresh access.
        if (state_q == ST_DONE && !cpu_en) begin
          state_d = ST_IDLE;
        end else begin
          stall = (wait_sel != 4'd0);
          if (adv) begin
            if (wait_sel != 4'd0) begin
              state_d = ST_WAIT;
              wcnt_d  = wait_sel;
            end else begin
              state_d  = ST_IDLE;
              complete = 1'b1;
            end
          end
        end
      end
    endcase

    if (complete && R_Wn) dout_d = (|hit) ? rdata_sel : '1;
  end

  always_ff @(posedge clk_96MHz or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      dout_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      live_q  <= live_d;
    end
  end

  assign wr_done = complete & ~R_Wn;
  assign wr_en   = wr_done & (|hit);
  assign sel     = live_q ? hit : '0;
  assign cpu_rdy = ~live_q | ~(halt | stall);
  assign dout    = dout_q;

  bus_irq_watchdog #(
    .IRQ_DIV  (IRQ_DIV),
    .WD_LIMIT (WD_LIMIT)
  ) u_irq_wd (
    .clk      (clk_96MHz),
    .rst      (RESET),
    .tick_3k  (tick_3k),
    .irq_ack  (wr_done & (addr == IRQACK_A)),
    .wd_clr   (wr_done & (addr == WDCLR_A)),
    .irq_n    (irq_n),
    .wd_reset (wd_reset)
  );

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb/tb_cpu_bus_fabric.sv - scoreboard bench for cpu_bus_fabric
`timescale 1ns/1ps
module tb_cpu_bus_fabric;

  localparam logic [63:0] BASES = {16'hC000, 16'hE000, 16'h2000, 16'h0000};
  localparam logic [63:0] MASKS = {16'hC000, 16'hF000, 16'hF000, 16'hF000};
  localparam logic [15:0] WAITS = {4'd1, 4'd0, 4'd2, 4'd0};

  logic        clk = 1'b0, rst = 1'b1, cpu_en = 1'b0, tick_3k = 1'b0, R_Wn = 1'b1, halt = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [31:0] rd_data = 32'hD3C2B1A0;
  logic [7:0]  dout;
  logic        cpu_rdy, wr_en, irq_n, wd_reset;
  logic [3:0]  sel;

  int total = 0, bad = 0, wd_pulses = 0;
  logic [7:0] exp_q[$];

  cpu_bus_fabric #(
    .NREG(4), .AW(16), .DW(8),
    .REG_BASE(BASES), .REG_MASK(MASKS), .REG_WAIT(WAITS),
    .IRQ_DIV(12), .WD_LIMIT(16),
    .IRQACK_A(16'h6080), .WDCLR_A(16'h5800)
  ) dut (
    .clk_96MHz(clk), .RESET(rst), .cpu_en(cpu_en), .tick_3k(tick_3k),
    .addr(addr), .R_Wn(R_Wn), .din(din), .dout(dout), .cpu_rdy(cpu_rdy),
    .halt(halt), .sel(sel), .wr_en(wr_en), .rd_data(rd_data),
    .irq_n(irq_n), .wd_reset(wd_reset)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wd_reset === 1'b1) wd_pulses++;

  function automatic int region_of(input logic [15:0] a);
    if ((a & 16'hF000) == 16'h0000) return 0;
    if ((a & 16'hF000) == 16'h2000) return 1;
    if ((a & 16'hF000) == 16'hE000) return 2;
    if ((a & 16'hC000) == 16'hC000) return 3;
    return -1;
  endfunction

  function automatic int wait_of(input int r);
    if (r == 1) return 2;
    if (r == 3) return 1;
    return 0;
  endfunction

  task automatic en_tick(output logic rdy, output int we_cycles);
    we_cycles = 0;
    @(negedge clk); cpu_en = 1'b1; #1;
    rdy = cpu_rdy;
    if (wr_en === 1'b1) we_cycles++;
    @(posedge clk); #1; cpu_en = 1'b0; #1;
    if (wr_en === 1'b1) we_cycles++;
    @(negedge clk);
    if (wr_en === 1'b1) we_cycles++;
    @(negedge clk);
  endtask

  task automatic pulse_3k(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); tick_3k = 1'b1;
      @(negedge clk); tick_3k = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic access(input logic [15:0] a, input logic rnw, input logic [7:0] wd, input string nm);
    int r, stalls, wes, w, exp_we;
    logic rdy;
    bit done;
    logic [3:0] exp_sel;
    logic [7:0] exp_d;
    r = region_of(a);
    exp_sel = (r < 0) ? 4'd0 : 4'(1 << r);
    addr = a; R_Wn = rnw; din = wd;
    if (rnw) exp_q.push_back((r < 0) ? 8'hFF : rd_data[8*r +: 8]);
    @(negedge clk); #1;
    total++;
    if (sel !== exp_sel) begin bad++; $display("FAIL %s sel got=%b exp=%b", nm, sel, exp_sel); end
    stalls = 0; wes = 0; done = 0;
    for (int k = 0; k < 32 && !done; k++) begin
      en_tick(rdy, w);
      wes += w;
      if (rdy === 1'b1) done = 1; else stalls++;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s timeout got=stalled exp=complete", nm); end
    total++;
    if (stalls != wait_of(r)) begin bad++; $display("FAIL %s stall_ticks got=%0d exp=%0d", nm, stalls, wait_of(r)); end
    exp_we = (!rnw && r >= 0) ? 1 : 0;
    total++;
    if (wes != exp_we) begin bad++; $display("FAIL %s wr_en_cycles got=%0d exp=%0d", nm, wes, exp_we); end
    if (rnw) begin
      exp_d = exp_q.pop_front();
      total++;
      if (dout !== exp_d) begin bad++; $display("FAIL %s dout got=%h exp=%h", nm, dout, exp_d); end
    end
  endtask

  task automatic test_reset();
    addr = 16'h2004; halt = 1'b1; cpu_en = 1'b1; R_Wn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (dout !== 8'h00)    begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (cpu_rdy !== 1'b1)  begin bad++; $display("FAIL reset_rdy got=%b exp=1", cpu_rdy); end
    total++; if (sel !== 4'b0000)   begin bad++; $display("FAIL reset_sel got=%b exp=0000", sel); end
    total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (irq_n !== 1'b1)    begin bad++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
    total++; if (wd_reset !== 1'b0) begin bad++; $display("FAIL reset_wd got=%b exp=0", wd_reset); end
    halt = 1'b0; cpu_en = 1'b0; R_Wn = 1'b1; addr = 16'h0000;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [15:0] tbl [7] = '{16'h2004, 16'hE000, 16'h9000, 16'h0123, 16'hC800, 16'hF000, 16'h5800};
    for (int i = 0; i < 7; i++) access(tbl[i], 1'b1, 8'h00, $sformatf("read_%h", tbl[i]));
  endtask

  task automatic test_write();
    access(16'h0010, 1'b0, 8'h5A, "write_r0");
    access(16'h9000, 1'b0, 8'h33, "write_unmapped");
    access(16'hC004, 1'b0, 8'h44, "write_r3");
  endtask

  task automatic test_back_to_back();
    access(16'h2FFF, 1'b1, 8'h00, "b2b_r1");
    access(16'h2000, 1'b1, 8'h00, "b2b_r1b");
    access(16'h0FFF, 1'b1, 8'h00, "b2b_r0");
  endtask

  task automatic test_halt();
    logic rdy; int w;
    addr = 16'h2004; R_Wn = 1'b1;
    exp_q.push_back(rd_data[15:8]);
    en_tick(rdy, w);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL halt_tick1 rdy got=%b exp=0", rdy); end
    en_tick(rdy, w);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL halt_tick2 rdy got=%b exp=0", rdy); end
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en_tick(rdy, w);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL halt_hold%0d rdy got=%b exp=0", k, rdy); end
    end
    #1; total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL halt_between rdy got=%b exp=0", cpu_rdy); end
    halt = 1'b0;
    en_tick(rdy, w);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL halt_release rdy got=%b exp=1", rdy); end
    total++; if (dout !== exp_q.pop_front()) begin bad++; $display("FAIL halt_dout got=%h exp=b1", dout); end
  endtask

  task automatic test_irq();
    do_reset();
    pulse_3k(11);
    #1; total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_early got=%b exp=1", irq_n); end
    pulse_3k(1);
    #1; total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_assert got=%b exp=0", irq_n); end
    addr = 16'h6080; R_Wn = 1'b0;
    @(negedge clk); cpu_en = 1'b1;
    @(posedge clk); #1; cpu_en = 1'b0;
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_ack got=%b exp=1", irq_n); end
    pulse_3k(11);
    #1; total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_pre_collide got=%b exp=1", irq_n); end
    @(negedge clk); cpu_en = 1'b1; tick_3k = 1'b1;
    @(posedge clk); #1; cpu_en = 1'b0; tick_3k = 1'b0;
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_collide got=%b exp=0", irq_n); end
    R_Wn = 1'b1; addr = 16'h0000;
  endtask

  task automatic test_watchdog();
    int base;
    do_reset();
    base = wd_pulses;
    pulse_3k(15 * 12);
    repeat (2) @(negedge clk);
    total++; if (wd_pulses - base != 0) begin bad++; $display("FAIL wd_early got=%0d exp=0", wd_pulses - base); end
    pulse_3k(12);
    repeat (3) @(negedge clk);
    total++; if (wd_pulses - base != 1) begin bad++; $display("FAIL wd_pulse got=%0d exp=1", wd_pulses - base); end
    do_reset();
    base = wd_pulses;
    pulse_3k(10 * 12);
    access(16'h5800, 1'b0, 8'h00, "wdclr_write");
    pulse_3k(10 * 12);
    repeat (2) @(negedge clk);
    total++; if (wd_pulses - base != 0) begin bad++; $display("FAIL wd_cleared got=%0d exp=0", wd_pulses - base); end
    pulse_3k(6 * 12);
    repeat (3) @(negedge clk);
    total++; if (wd_pulses - base != 1) begin bad++; $display("FAIL wd_after_clear got=%0d exp=1", wd_pulses - base); end
  endtask

  task automatic test_reset_mid_access();
    logic rdy; int w;
    access(16'hE010, 1'b1, 8'h00, "pre_abort_read");
    addr = 16'h2004; R_Wn = 1'b1;
    en_tick(rdy, w);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL abort_stall rdy got=%b exp=0", rdy); end
    @(negedge clk); #2; rst = 1'b1; #1;
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", cpu_rdy); end
    total++; if (sel !== 4'b0000)  begin bad++; $display("FAIL abort_sel got=%b exp=0000", sel); end
    total++; if (dout !== 8'h00)   begin bad++; $display("FAIL abort_dout got=%h exp=00", dout); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    access(16'h0040, 1'b1, 8'h00, "post_abort_read");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_write();
    test_back_to_back();
    test_halt();
    test_irq();
    test_watchdog();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
